bp_be_fe_pairer: RTL and testbench
==================================

# bp_be_fe_pairer

Pairing buffer between the FE queue interface and `bp_be_issue_queue`. It accepts at most one FE queue packet per cycle and holds packets in a 4-entry in-order FIFO. It presents them to the issue queue as an ordered pair (slot 1 older, slot 2 younger) or as a single packet in slot 1. Non-fetch messages are never paired, and a lone fetch packet is released solo after a programmable wait.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: processor configuration; supplies `fe_queue_width_lp`.
- `single_timeout_p`, default 2: cycles a lone fetch packet waits at the head before it is sent solo. 0 means it is sent immediately.
- `els_p`, default 4: FIFO depth. Must be a power of two and at least 2.
- `clk_i`  in  1  clock; all state is rising-edge.
- `reset_n_i`  in  1  reset, asynchronous assert, active-low.
- `clr_v_i`  in  1  flush from the director; discards all held packets.
- `fe_queue_i`  in  `fe_queue_width_lp`  packet (`bp_fe_queue_s`) from FE.
- `fe_queue_v_i`  in  1  packet valid.
- `fe_queue_ready_o`  out  1  block can accept a packet this cycle.
- `fe_queue1_o`  out  `fe_queue_width_lp`  older output packet.
- `fe_queue2_o`  out  `fe_queue_width_lp`  younger output packet.
- `fe_queue_v1_o`  out  1  slot 1 valid.
- `fe_queue_v2_o`  out  1  slot 2 valid. Never 1 unless `fe_queue_v1_o` is 1.
- `fe_queue_ready_i`  in  1  issue queue ready (its `fe_queue_ready_o`).

## Operation
- **State**
  - Read pointer and write pointer, each `clog2(els_p)` bits plus a wrap bit.
  - Occupancy count, 0 to `els_p`.
  - Wait counter, `clog2(single_timeout_p+1)` bits, saturating.
- **Enqueue:** `enq = fe_queue_v_i & fe_queue_ready_o`. The packet is written at the write pointer.
- **`fe_queue_ready_o`** = `~clr_v_i & (count < els_p)`. Simultaneous dequeue does not raise ready in the same cycle.
- **A packet is "fetch"** when `msg_type == e_instr_fetch`. All other message types are "solo-only".
- **Output selection** is evaluated from registered state only, in this priority order:
  1. `count == 0`: `v1 = v2 = 0`.
  2. Head is solo-only: `v1 = 1`, `v2 = 0`.
  3. `count >= 2`, head is fetch, and head+1 is fetch: `v1 = v2 = 1`.
  4. `count >= 2`, head is fetch, and head+1 is solo-only: `v1 = 1`, `v2 = 0`.
  5. `count == 1` and head is fetch: `v1 = (wait_cnt >= single_timeout_p)`, `v2 = 0`.
- `fe_queue1_o` always shows the head packet and `fe_queue2_o` the head+1 packet, valid or not, so there are no data muxes on valid.
- **Dequeue:** `deq_n = fe_queue_ready_i ? (v1 + v2) : 0`. The read pointer advances by `deq_n`.
- **Count update:** `count_next = count + enq - deq_n`.
- **Wait counter:**
  - Increments (saturating) each cycle that case 5 holds with `v1 = 0`.
  - Clears on any cycle where case 5 does not hold, or where an enqueue occurs.
  - A new arrival therefore restarts the wait, which lets it pair.
- **Flush (`clr_v_i = 1`):**
  - Pointers, count, and wait counter go to 0 at the next edge.
  - The input is dropped and output valids are ignored.
  - Flush overrides an enqueue or dequeue in the same cycle.
- **Wrap-around:** pointers wrap modulo `els_p` with the wrap bit toggled. A pair whose head is at `els_p-1` reads slot 2 from index 0.
- **Reset (`reset_n_i` low):** takes effect asynchronously and immediately regardless of the clock, and yields the same state as a flush. Release is synchronised by the integrator.

## Timing
- **Reset values:**
  - `fe_queue_v1_o = 0`, `fe_queue_v2_o = 0`.
  - `fe_queue_ready_o = 1` (unless `clr_v_i` is high).
  - `fe_queue1_o` and `fe_queue2_o` are undefined/don't-care.
- **Latency:**
  - A packet enqueued at edge N is visible at the outputs in cycle N+1 at the earliest. There is no input-to-output bypass.
  - Paired latency is 1 cycle.
  - Solo fetch latency is `1 + single_timeout_p` cycles when no partner arrives.
- The output valids depend only on flops. `fe_queue_ready_i` affects only the next state, so there is no combinational path from `fe_queue_ready_i` to the outputs.
- Steady-state throughput is 1 packet/cycle in and up to 2 packets/cycle out.
- A flush asserted in cycle N yields empty outputs in cycle N+1. `fe_queue_ready_o` is 0 only during cycle N.

## Test plan
- **Pairing:** reset, then enqueue fetch A at cycle 0 and fetch B at cycle 1, with `fe_queue_ready_i = 1`.
  - Cycle 2: `v1 = v2 = 1`, slot 1 = A, slot 2 = B.
  - Cycle 3: `v1 = 0`, count = 0.
- **Solo timeout:** `single_timeout_p = 2`, enqueue lone fetch A at cycle 0.
  - Cycles 1–2: `v1 = 0`.
  - Cycle 3: `v1 = 1`, `v2 = 0`, A dequeued.
  - Variant: fetch B arriving at cycle 2 instead gives pair (A, B) at cycle 3.
- **Solo-only message:** enqueue fetch A, then an itlb-miss message X, then fetch C.
  - Outputs in order: A solo, then X solo, then C.
  - `v2` is never 1 while X is at the head or head+1.
- **Full/backpressure:** hold `fe_queue_ready_i = 0` and drive `fe_queue_v_i = 1` for 6 cycles.
  - Exactly 4 packets are accepted.
  - `fe_queue_ready_o = 0` from cycle 4 onward.
  - After releasing `fe_queue_ready_i`: 2 pairs in 2 cycles, in order, with the pair across the wrap index 3→0 correct.
- **Flush:** with 3 packets held, assert `clr_v_i` for 1 cycle together with `fe_queue_v_i = 1`.
  - Next cycle: `v1 = v2 = 0` and count = 0.
  - The packet presented during the flush is not stored.
- **Asynchronous reset mid-operation:** drop `reset_n_i` between clock edges while outputs are valid.
  - `fe_queue_v1_o` and `fe_queue_v2_o` go to 0 before the next edge.
  - After release, `fe_queue_ready_o = 1`.

Source files
------------

// File: rtl/bp_be_fe_pairer.sv
// bp_be_fe_pairer
//   Pairing buffer between the FE queue and the issue queue. Holds up to els_p
//   FE packets in order and presents them as an (older, younger) pair or as a
//   single packet in slot 1. Non-fetch messages always go out alone; a lone
//   fetch packet is released solo after single_timeout_p cycles at the head.
//
// Parameters
//   bp_params_p       processor configuration (0 = default cfg, 39-bit vaddr;
//                     any other value selects a 32-bit vaddr layout)
//   single_timeout_p  cycles a lone fetch waits before going out solo
//   els_p             FIFO depth, power of two, >= 2
//
// Ports
//   clk_i             clock, rising edge
//   reset_n_i         asynchronous active-low reset
//   clr_v_i           flush, discards all held packets
//   fe_queue_i        packet from FE: {msg_type[1:0], vaddr, instr}
//   fe_queue_v_i      packet valid
//   fe_queue_ready_o  packet can be accepted this cycle
//   fe_queue1_o       head (older) packet, always driven
//   fe_queue2_o       head+1 (younger) packet, always driven
//   fe_queue_v1_o     slot 1 valid
//   fe_queue_v2_o     slot 2 valid (only with slot 1)
//   fe_queue_ready_i  issue queue ready
module bp_be_fe_pairer #(
  parameter int unsigned bp_params_p      = 0,
  parameter int unsigned single_timeout_p = 2,
  parameter int unsigned els_p            = 4,
  localparam int unsigned vaddr_width_lp    = (bp_params_p == 0) ? 39 : 32,
  localparam int unsigned fe_queue_width_lp = 2 + vaddr_width_lp + 32
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         clr_v_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue1_o,
  output logic [fe_queue_width_lp-1:0] fe_queue2_o,
  output logic                         fe_queue_v1_o,
  output logic                         fe_queue_v2_o,
  input  logic                         fe_queue_ready_i
);

  typedef enum logic [1:0] {
    e_instr_fetch        = 2'd0,
    e_itlb_miss          = 2'd1,
    e_instr_page_fault   = 2'd2,
    e_instr_access_fault = 2'd3
  } msg_type_e;

  localparam int unsigned PTR_W  = $clog2(els_p);
  localparam int unsigned PTRF_W = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(els_p + 1);
  localparam int unsigned WAIT_W = (single_timeout_p == 0) ? 1 : $clog2(single_timeout_p + 1);

  logic [fe_queue_width_lp-1:0] r_mem [els_p];
  logic [PTRF_W-1:0]            r_rd_ptr;
  logic [PTRF_W-1:0]            r_wr_ptr;
  logic [CNT_W-1:0]             r_count;
  logic [WAIT_W-1:0]            r_wait;

  logic [PTR_W-1:0] w_head_idx;
  logic [PTR_W-1:0] w_next_idx;
  msg_type_e        w_head_type;
  msg_type_e        w_next_type;
  logic             w_head_fetch;
  logic             w_next_fetch;
  logic             w_lone_fetch;
  logic             w_enq;
  logic [1:0]       w_deq_n;

  assign w_head_idx = r_rd_ptr[PTR_W-1:0];
  // Power-of-two depth: the index add wraps els_p-1 -> 0 on its own.
  assign w_next_idx = w_head_idx + PTR_W'(1);

  assign fe_queue1_o = r_mem[w_head_idx];
  assign fe_queue2_o = r_mem[w_next_idx];

  assign w_head_type  = msg_type_e'(fe_queue1_o[fe_queue_width_lp-1 -: 2]);
  assign w_next_type  = msg_type_e'(fe_queue2_o[fe_queue_width_lp-1 -: 2]);
  assign w_head_fetch = (w_head_type == e_instr_fetch);
  assign w_next_fetch = (w_next_type == e_instr_fetch);

  assign fe_queue_ready_o = ~clr_v_i & (r_count < CNT_W'(els_p));
  assign w_enq            = fe_queue_v_i & fe_queue_ready_o;

  always_comb begin
    fe_queue_v1_o = 1'b0;
    fe_queue_v2_o = 1'b0;
    w_lone_fetch  = 1'b0;
    if (r_count == '0) begin
      fe_queue_v1_o = 1'b0;
    end else if (!w_head_fetch) begin
      fe_queue_v1_o = 1'b1;
    end else if (r_count >= CNT_W'(2)) begin
      fe_queue_v1_o = 1'b1;
      fe_queue_v2_o = w_next_fetch;
    end else begin
      w_lone_fetch  = 1'b1;
      fe_queue_v1_o = (r_wait >= WAIT_W'(single_timeout_p));
    end
  end

  assign w_deq_n = fe_queue_ready_i ? ({1'b0, fe_queue_v1_o} + {1'b0, fe_queue_v2_o}) : 2'd0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_wait   <= '0;
    end else if (clr_v_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_wait   <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTRF_W'(w_deq_n);
      r_wr_ptr <= r_wr_ptr + PTRF_W'(w_enq);
      r_count  <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq_n);
      // An arrival restarts the wait so the lone fetch gets a chance to pair.
      if (!w_lone_fetch || w_enq) begin
        r_wait <= '0;
      end else if (!fe_queue_v1_o && (r_wait != '1)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= fe_queue_i;
    end
  end

  // Pointer distance (wrap bits included) must always equal the occupancy.
  a_ptr_count: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    CNT_W'(r_wr_ptr - r_rd_ptr) == r_count);
  a_v2_needs_v1: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_v2_o |-> fe_queue_v1_o);

endmodule

// File: tb/tb_bp_be_fe_pairer.sv
module tb_bp_be_fe_pairer;

  localparam int unsigned W    = 73;
  localparam int unsigned ELS  = 4;
  localparam int unsigned TOUT = 2;

  logic         clk;
  logic         reset_n;
  logic         clr_v_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue1_o;
  logic [W-1:0] fe_queue2_o;
  logic         fe_queue_v1_o;
  logic         fe_queue_v2_o;
  logic         fe_queue_ready_i;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;

  // Reference model: the ordered list of held packets plus the number of
  // cycles the lone fetch at the head has been waiting since its last arrival.
  logic [W-1:0] m_q[$];
  int           m_wait = 0;

  bp_be_fe_pairer #(
    .bp_params_p      (0),
    .single_timeout_p (TOUT),
    .els_p            (ELS)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .clr_v_i          (clr_v_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue1_o      (fe_queue1_o),
    .fe_queue2_o      (fe_queue2_o),
    .fe_queue_v1_o    (fe_queue_v1_o),
    .fe_queue_v2_o    (fe_queue_v2_o),
    .fe_queue_ready_i (fe_queue_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic is_fetch(input logic [W-1:0] p);
    return p[W-1 -: 2] == 2'd0;
  endfunction

  function automatic logic [W-1:0] mk(input logic [1:0] mt);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return {mt, r[W-3:0]};
  endfunction

  // Monitor/scoreboard: compare at the falling edge, then advance the model
  // for the coming rising edge (inputs are stable until after that edge).
  always @(negedge clk) begin
    logic ev1, ev2, exp_ready, enq, lone;
    if (!reset_n) begin
      m_q.delete();
      m_wait = 0;
      chk("rst_v1", W'(fe_queue_v1_o), W'(0));
      chk("rst_v2", W'(fe_queue_v2_o), W'(0));
      chk("rst_ready", W'(fe_queue_ready_o), W'(!clr_v_i));
    end else begin
      exp_ready = !clr_v_i && (m_q.size() < ELS);
      ev1 = 1'b0;
      ev2 = 1'b0;
      if (m_q.size() == 0) begin
        ev1 = 1'b0;
      end else if (!is_fetch(m_q[0])) begin
        ev1 = 1'b1;
      end else if (m_q.size() >= 2) begin
        ev1 = 1'b1;
        ev2 = is_fetch(m_q[1]);
      end else begin
        ev1 = (m_wait >= TOUT);
      end
      chk("ready", W'(fe_queue_ready_o), W'(exp_ready));
      chk("v1", W'(fe_queue_v1_o), W'(ev1));
      chk("v2", W'(fe_queue_v2_o), W'(ev2));
      if (ev1 && fe_queue_v1_o) chk("slot1", fe_queue1_o, m_q[0]);
      if (ev2 && fe_queue_v2_o) chk("slot2", fe_queue2_o, m_q[1]);

      if (clr_v_i) begin
        m_q.delete();
        m_wait = 0;
      end else begin
        lone = (m_q.size() == 1) && is_fetch(m_q[0]);
        enq  = fe_queue_v_i && exp_ready;
        if (fe_queue_ready_i) begin
          if (ev1) void'(m_q.pop_front());
          if (ev2) void'(m_q.pop_front());
        end
        if (enq) m_q.push_back(fe_queue_i);
        if (!lone || enq) m_wait = 0;
        else if (!ev1) m_wait++;
      end
    end
  end

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic rdy, input logic clr);
    fe_queue_v_i     = v;
    fe_queue_i       = d;
    fe_queue_ready_i = rdy;
    clr_v_i          = clr;
    #1;
    if (v && fe_queue_ready_o) n_acc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, mk(2'd0), rdy, 1'b0);
  endtask

  initial begin
    reset_n          = 1'b0;
    clr_v_i          = 1'b0;
    fe_queue_v_i     = 1'b0;
    fe_queue_i       = '0;
    fe_queue_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Pairing: fetch A then fetch B.
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    idle(3, 1'b1);

    // Solo timeout, then the variant where a partner arrives in time.
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    idle(5, 1'b1);
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    idle(1, 1'b1);
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    idle(3, 1'b1);

    // Solo-only message between two fetches.
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    cyc(1'b1, mk(2'd1), 1'b1, 1'b0);
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    idle(6, 1'b1);

    // Full/backpressure with the read pointer parked at index 1.
    cyc(1'b0, mk(2'd0), 1'b1, 1'b1);
    cyc(1'b1, mk(2'd1), 1'b1, 1'b0);
    idle(1, 1'b1);
    n_acc = 0;
    for (int i = 0; i < 6; i++) cyc(1'b1, mk(2'd0), 1'b0, 1'b0);
    chk("full_accepted", W'(n_acc), W'(4));
    idle(3, 1'b1);

    // Flush with three held packets and a packet presented during the flush.
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(2'd0), 1'b0, 1'b0);
    cyc(1'b1, mk(2'd0), 1'b0, 1'b1);
    idle(1, 1'b1);
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] mt;
      mt = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cyc($urandom_range(0, 2) != 0, mk(mt), $urandom_range(0, 3) != 0,
          $urandom_range(0, 63) == 0);
    end
    idle(6, 1'b1);

    // Asynchronous reset between edges while a pair is presented.
    cyc(1'b1, mk(2'd0), 1'b0, 1'b0);
    cyc(1'b1, mk(2'd0), 1'b0, 1'b0);
    cyc(1'b0, mk(2'd0), 1'b0, 1'b0);
    #2;
    chk("pre_arst_v1", W'(fe_queue_v1_o), W'(1));
    reset_n = 1'b0;
    #1;
    chk("arst_v1", W'(fe_queue_v1_o), W'(0));
    chk("arst_v2", W'(fe_queue_v2_o), W'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("post_arst_ready", W'(fe_queue_ready_o), W'(1));
    @(posedge clk);
    #1;
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    cyc(1'b1, mk(2'd0), 1'b1, 1'b0);
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
